// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//   Synchronises, debounces and edge-detects three raw pushbuttons (next, ok,
//   prev) and turns each accepted press into a single-cycle pulse. These pulses
//   feed the button_*_i inputs of the LCD controller.
//
//   Optional feature macro: BUTTON_COND_AUTOREPEAT_EN
//     When defined, next and prev auto-repeat while held. The first repeat comes
//     REPEAT_DELAY_CYCLES after the press pulse. Later repeats come every
//     REPEAT_PERIOD_CYCLES. ok never repeats. When the macro is undefined, no
//     repeat logic is built.
//
// Parameters
//   DEBOUNCE_CYCLES      consecutive stable synchronised samples needed (>= 2)
//   REPEAT_DELAY_CYCLES  press pulse to first repeat pulse (autorepeat only)
//   REPEAT_PERIOD_CYCLES spacing of later repeat pulses (autorepeat only)
//
// Ports
//   fpga_clk_i                single clock, rising edge
//   fpga_reset_i              asynchronous active-low reset
//   button_{next,ok,prev}_raw_i  raw bouncing active-high buttons
//   button_{next,ok,prev}_o   registered single-cycle press pulses
//                             (at most one is high in any cycle)
//   held_o[2:0]               debounced levels {prev, ok, next}
// -----------------------------------------------------------------------------
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES      = 4,
    parameter int REPEAT_DELAY_CYCLES  = 16,
    parameter int REPEAT_PERIOD_CYCLES = 8
) (
    input  logic       fpga_clk_i,
    input  logic       fpga_reset_i,
    input  logic       button_next_raw_i,
    input  logic       button_ok_raw_i,
    input  logic       button_prev_raw_i,
    output logic       button_next_o,
    output logic       button_ok_o,
    output logic       button_prev_o,
    output logic [2:0] held_o
);

    localparam int IDX_NEXT = 0;
    localparam int IDX_OK   = 1;
    localparam int IDX_PREV = 2;

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    // The count value at which one more mismatching sample completes the debounce.
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY_CYCLES < 1 || REPEAT_PERIOD_CYCLES < 1) begin : g_param_check
        $error("button_conditioner: illegal parameter value");
    end

    logic [2:0]    w_raw;
    logic [2:0]    r_sync1;
    logic [2:0]    r_sync2;
    logic [2:0]    r_stable;
    logic [2:0]    w_stable_nxt;
    logic [CW-1:0] r_cnt     [3];
    logic [CW-1:0] w_cnt_nxt [3];
    logic [2:0]    w_press;
    logic [2:0]    w_cand;
    logic [2:0]    w_pulse_nxt;
    logic [2:0]    r_pulse;

    assign w_raw = {button_prev_raw_i, button_ok_raw_i, button_next_raw_i};

    // Two-flop synchroniser for the asynchronous raw buttons.
    always_ff @(posedge fpga_clk_i or negedge fpga_reset_i) begin
        if (!fpga_reset_i) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce next-state: count mismatching samples and toggle stable on the last one.
    always_comb begin
        for (int b = 0; b < 3; b++) begin
            w_stable_nxt[b] = r_stable[b];
            w_cnt_nxt[b]    = CNT_ZERO;
            if (r_sync2[b] == r_stable[b]) begin
                w_cnt_nxt[b] = CNT_ZERO;
            end else if (r_cnt[b] == CNT_LAST) begin
                w_stable_nxt[b] = ~r_stable[b];
                w_cnt_nxt[b]    = CNT_ZERO;
            end else begin
                w_cnt_nxt[b] = r_cnt[b] + CNT_ONE;
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge fpga_clk_i or negedge fpga_reset_i) begin
        if (!fpga_reset_i) begin
            r_stable <= 3'b000;
            for (int b = 0; b < 3; b++) begin
                r_cnt[b] <= CNT_ZERO;
            end
        end else begin
            r_stable <= w_stable_nxt;
            for (int b = 0; b < 3; b++) begin
                r_cnt[b] <= w_cnt_nxt[b];
            end
        end
    end

    // A press is the edge on which stable goes from 0 to 1. Releases give no pulse.
    assign w_press = w_stable_nxt & ~r_stable;

`ifdef BUTTON_COND_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                          REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int            RW          = $clog2(RMAX) + 1;
    localparam logic [RW-1:0] REP_ZERO    = {RW{1'b0}};
    localparam logic [RW-1:0] REP_ONE     = RW'(1);
    localparam logic [RW-1:0] REP_DLY_LD  = RW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RW-1:0] REP_PER_LD  = RW'(REPEAT_PERIOD_CYCLES - 1);

    // Only next (r=0) and prev (r=1) get a repeat timer. ok never repeats.
    for (genvar r = 0; r < 2; r++) begin : g_rep
        localparam int B = (r == 0) ? IDX_NEXT : IDX_PREV;
        logic [RW-1:0] r_rep;
        logic [RW-1:0] w_rep_nxt;
        logic          w_fire;

        // Repeat timer. It is loaded on the press and reloaded on each repeat.
        // A release that takes effect on this edge suppresses the repeat.
        always_comb begin
            w_fire    = r_stable[B] & w_stable_nxt[B] & (r_rep == REP_ZERO);
            w_rep_nxt = r_rep;
            if (w_press[B]) begin
                w_rep_nxt = REP_DLY_LD;
            end else if (!w_stable_nxt[B]) begin
                w_rep_nxt = REP_ZERO;
            end else if (w_fire) begin
                w_rep_nxt = REP_PER_LD;
            end else if (r_rep != REP_ZERO) begin
                w_rep_nxt = r_rep - REP_ONE;
            end else begin
                w_rep_nxt = r_rep;
            end
        end

        // Repeat timer register.
        always_ff @(posedge fpga_clk_i or negedge fpga_reset_i) begin
            if (!fpga_reset_i) begin
                r_rep <= REP_ZERO;
            end else begin
                r_rep <= w_rep_nxt;
            end
        end
    end

    assign w_cand = w_press | {g_rep[1].w_fire, 1'b0, g_rep[0].w_fire};
`else
    assign w_cand = w_press;
`endif

    // Only one pulse per cycle. The priority is ok > next > prev. A losing pulse is dropped.
    always_comb begin
        w_pulse_nxt = 3'b000;
        if (w_cand[IDX_OK]) begin
            w_pulse_nxt[IDX_OK] = 1'b1;
        end else if (w_cand[IDX_NEXT]) begin
            w_pulse_nxt[IDX_NEXT] = 1'b1;
        end else if (w_cand[IDX_PREV]) begin
            w_pulse_nxt[IDX_PREV] = 1'b1;
        end else begin
            w_pulse_nxt = 3'b000;
        end
    end

    // Registered pulse outputs.
    always_ff @(posedge fpga_clk_i or negedge fpga_reset_i) begin
        if (!fpga_reset_i) begin
            r_pulse <= 3'b000;
        end else begin
            r_pulse <= w_pulse_nxt;
        end
    end

    assign button_next_o = r_pulse[IDX_NEXT];
    assign button_ok_o   = r_pulse[IDX_OK];
    assign button_prev_o = r_pulse[IDX_PREV];
    assign held_o        = r_stable;

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//   Table-driven bench for button_conditioner with DEBOUNCE_CYCLES=4,
//   REPEAT_DELAY_CYCLES=16 and REPEAT_PERIOD_CYCLES=8. Each record holds reset,
//   the raw {prev,ok,next} buttons driven before an edge, and the pulse/held
//   values expected just after that edge. A hand-written sequence covers the
//   long prev hold, whose expected pulses depend on BUTTON_COND_AUTOREPEAT_EN.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

    typedef struct {
        string      tag;
        logic       rst_n;
        logic [2:0] raw;
        logic [2:0] exp_pulse;
        logic [2:0] exp_held;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] raw = 3'b000;
    logic       next_o;
    logic       ok_o;
    logic       prev_o;
    logic [2:0] held;

    int n_applied = 0;
    int n_miss    = 0;
    vec_t vecs[$];

`ifdef BUTTON_COND_AUTOREPEAT_EN
    int prev_pulse_at [7] = '{5, 21, 29, 37, 45, 53, 61};
`else
    int prev_pulse_at [1] = '{5};
`endif

    button_conditioner #(
        .DEBOUNCE_CYCLES      (4),
        .REPEAT_DELAY_CYCLES  (16),
        .REPEAT_PERIOD_CYCLES (8)
    ) dut (
        .fpga_clk_i        (clk),
        .fpga_reset_i      (rst_n),
        .button_next_raw_i (raw[0]),
        .button_ok_raw_i   (raw[1]),
        .button_prev_raw_i (raw[2]),
        .button_next_o     (next_o),
        .button_ok_o       (ok_o),
        .button_prev_o     (prev_o),
        .held_o            (held)
    );

    always #5 clk = ~clk;

    task automatic add(input string tag, input int n, input logic r,
                       input logic [2:0] rw, input logic [2:0] ep, input logic [2:0] eh);
        vec_t v;
        v.tag = tag; v.rst_n = r; v.raw = rw; v.exp_pulse = ep; v.exp_held = eh;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    // Drive on the falling edge, let one rising edge happen, then compare 1 time unit later.
    task automatic step_and_check(input string tag, input int idx, input logic r,
                                  input logic [2:0] rw, input logic [2:0] ep, input logic [2:0] eh);
        logic [2:0] act_pulse;
        @(negedge clk);
        rst_n = r;
        raw   = rw;
        @(posedge clk);
        #1;
        act_pulse = {prev_o, ok_o, next_o};
        n_applied++;
        if (act_pulse !== ep || held !== eh) begin
            n_miss++;
            $display("FAIL %s vec %0d: got pulse=%b held=%b, expected pulse=%b held=%b",
                     tag, idx, act_pulse, held, ep, eh);
        end
    endtask

    initial begin
        // Reset holds everything at 0 while the raw inputs toggle. Releasing reset with idle inputs keeps them at 0.
        add("reset_toggle", 1, 1'b0, 3'b111, 3'b000, 3'b000);
        add("reset_toggle", 1, 1'b0, 3'b000, 3'b000, 3'b000);
        add("reset_toggle", 1, 1'b0, 3'b101, 3'b000, 3'b000);
        add("reset_toggle", 1, 1'b0, 3'b010, 3'b000, 3'b000);
        add("reset_release", 3, 1'b1, 3'b000, 3'b000, 3'b000);
        // ok is first sampled at e0. The pulse follows edge e0+5. The release takes the same latency.
        add("ok_press",   5, 1'b1, 3'b010, 3'b000, 3'b000);
        add("ok_press",   1, 1'b1, 3'b010, 3'b010, 3'b010);
        add("ok_press",   2, 1'b1, 3'b010, 3'b000, 3'b010);
        add("ok_release", 5, 1'b1, 3'b000, 3'b000, 3'b010);
        add("ok_release", 2, 1'b1, 3'b000, 3'b000, 3'b000);
        // next bounces 2 high, 1 low, 2 high. It is never accepted.
        add("next_bounce", 2, 1'b1, 3'b001, 3'b000, 3'b000);
        add("next_bounce", 1, 1'b1, 3'b000, 3'b000, 3'b000);
        add("next_bounce", 2, 1'b1, 3'b001, 3'b000, 3'b000);
        add("next_bounce", 6, 1'b1, 3'b000, 3'b000, 3'b000);
        // ok and next are pressed together. Only ok pulses, and both are held.
        add("ok_next_same", 5, 1'b1, 3'b011, 3'b000, 3'b000);
        add("ok_next_same", 1, 1'b1, 3'b011, 3'b010, 3'b011);
        add("ok_next_same", 1, 1'b1, 3'b011, 3'b000, 3'b011);
        add("ok_next_rel",  5, 1'b1, 3'b000, 3'b000, 3'b011);
        add("ok_next_rel",  2, 1'b1, 3'b000, 3'b000, 3'b000);
        // Reset hits 2 cycles after next rises. The pulse comes 5 edges after the first post-reset sample.
        add("next_reset", 2, 1'b1, 3'b001, 3'b000, 3'b000);
        add("next_reset", 2, 1'b0, 3'b001, 3'b000, 3'b000);
        add("next_after_rst", 5, 1'b1, 3'b001, 3'b000, 3'b000);
        add("next_after_rst", 1, 1'b1, 3'b001, 3'b001, 3'b001);
        add("next_after_rst", 2, 1'b1, 3'b001, 3'b000, 3'b001);
        add("next_after_rel", 5, 1'b1, 3'b000, 3'b000, 3'b001);
        add("next_after_rel", 2, 1'b1, 3'b000, 3'b000, 3'b000);

        for (int i = 0; i < vecs.size(); i++) begin
            step_and_check(vecs[i].tag, i, vecs[i].rst_n, vecs[i].raw,
                           vecs[i].exp_pulse, vecs[i].exp_held);
        end

        // prev is held for 60 samples (offsets 0..59). The release is accepted at offset 65.
        for (int off = 0; off <= 70; off++) begin
            logic [2:0] ep;
            logic [2:0] eh;
            ep = 3'b000;
            foreach (prev_pulse_at[k]) begin
                if (prev_pulse_at[k] == off) ep = 3'b100;
            end
            eh = (off >= 5 && off <= 64) ? 3'b100 : 3'b000;
            step_and_check("prev_hold", off, 1'b1, (off < 60) ? 3'b100 : 3'b000, ep, eh);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, which is the number of consecutive stable synchronized samples required to accept a level change; legal values are 2 or more.
REQ-002 SHALL have parameter REPEAT_DELAY_CYCLES, default 16, which is the number of cycles from a press pulse to the first repeat pulse.
REQ-003 SHALL have parameter REPEAT_PERIOD_CYCLES, default 8, which is the number of cycles between subsequent repeat pulses.
REQ-004 fpga_clk_i  input  1  single clock; all state updates on the rising edge.
REQ-005 fpga_reset_i  input  1  reset, asynchronous, active-low.
REQ-006 button_next_raw_i, button_ok_raw_i, button_prev_raw_i  input  1 each  raw pushbuttons; asynchronous, bouncing, active-high.
REQ-007 button_next_o, button_ok_o, button_prev_o  output  1 each  single-cycle press pulses; these feed the LCD controller button_*_i inputs.
REQ-008 held_o  output  3  debounced levels {prev, ok, next}, bit 0 = next.

Function
REQ-009 Each raw input SHALL pass through a two-flop synchronizer before any other logic.
REQ-010 Each button SHALL keep a stable bit and a counter of width clog2(DEBOUNCE_CYCLES+1).
REQ-011 On each edge, if the synchronized value equals stable, the counter SHALL clear; otherwise the counter SHALL increment.
REQ-012 When the increment would reach DEBOUNCE_CYCLES, stable SHALL toggle and the counter SHALL clear on the same edge.
REQ-013 Any bounce shorter than DEBOUNCE_CYCLES synchronized cycles SHALL restart the count and SHALL produce no stable change and no pulse.
REQ-014 Press pulse outputs SHALL be registered; the candidate pulse rises on the edge at which stable goes 0 to 1.
REQ-015 Latency: if raw is first sampled high at edge e0 and held, the pulse SHALL be high from edge e0+DEBOUNCE_CYCLES+1 for exactly one cycle.
REQ-016 A release (stable going 1 to 0) SHALL produce no pulse; it follows the same debounce latency.
REQ-017 If more than one pulse would fire in the same cycle, only one SHALL be emitted, with priority ok > next > prev; lower-priority pulses are dropped, not deferred.
REQ-018 At most one of the three pulse outputs SHALL be high in any cycle.
REQ-019 held_o SHALL equal the stable bits directly, with no extra register stage.

Reset
REQ-020 While fpga_reset_i=0, all synchronizer flops, stable bits, counters, repeat state and outputs SHALL be 0, asynchronously.
REQ-021 Reset asserted mid-debounce or mid-repeat SHALL abort the operation with no pulse.
REQ-022 A button held through reset deassertion SHALL produce one press pulse at DEBOUNCE_CYCLES+1 edges after its first post-reset sample.

Configuration
REQ-023 With macro BUTTON_COND_AUTOREPEAT_EN defined, next and prev SHALL auto-repeat while their stable bit stays 1:
- first repeat pulse REPEAT_DELAY_CYCLES cycles after the press pulse;
- then one pulse every REPEAT_PERIOD_CYCLES cycles;
- repeat pulses obey REQ-017 priority;
- ok SHALL never repeat;
- stable going to 0 SHALL stop repeating immediately.
REQ-024 Without BUTTON_COND_AUTOREPEAT_EN, exactly one pulse SHALL be emitted per accepted press, the REPEAT_* parameters SHALL be unused, and no repeat counter SHALL be synthesized.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=16, REPEAT_PERIOD_CYCLES=8)
REQ-025 Reset low, raw inputs toggling -> all outputs 0; release reset with raw inputs 0 -> outputs stay 0.
REQ-026 button_ok_raw_i rises before edge 0 and is held -> button_ok_o high during the cycle after edge 5 only; held_o[1]=1 from edge 5.
REQ-027 button_next_raw_i pulses high for 2 cycles, low for 1, high for 2, then low -> no pulse, held_o stays 0.
REQ-028 ok and next raw rise in the same cycle -> single button_ok_o pulse, no button_next_o pulse; held_o=3'b011.
REQ-029 prev held for 60 cycles -> with macro: pulses at press, +16, +24, +32, ... until release; without macro: exactly one pulse.
REQ-030 fpga_reset_i driven low 2 cycles after next raw rises, then released while next is still held -> no pulse during reset; one pulse 5 edges after the first post-reset sample.
